// File: rtl/uart_spi_bridge_if.sv
// Pin bundle for uart_spi_bridge: UART serial lines plus SPI bus.
// master = bridge side, slave = attached UART peer and SPI slave.
interface uart_spi_bridge_if;
  logic uart_rx_d_in;
  logic uart_tx_d_out;
  logic cs_bar;
  logic sclk;
  logic mosi;
  logic miso;

  modport master (
    input  uart_rx_d_in,
    input  miso,
    output uart_tx_d_out,
    output cs_bar,
    output sclk,
    output mosi
  );

  modport slave (
    output uart_rx_d_in,
    output miso,
    input  uart_tx_d_out,
    input  cs_bar,
    input  sclk,
    input  mosi
  );
endinterface

// File: rtl/uart_spi_bridge.sv
// UART-to-SPI-master bridge: UART words go out as SPI frames,
// the MISO word of each frame is returned on the UART.
module uart_spi_bridge #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_DIV   = 16,
  parameter int SCLK_DIV   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        freq_control,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              spi_enable,
  uart_spi_bridge_if.master bus,
  output logic              uart_rx_valid,
  output logic              uart_tx_ready,
  output logic              spi_rx_valid,
  output logic              spi_tx_done,
  output logic              frame_err,
  output logic              overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int BCW = $clog2(BAUD_DIV * 8 + 1);
  localparam int SCW = $clog2(SCLK_DIV * 8 + 1);
  localparam int BIW = $clog2(DATA_W);
  localparam int EW  = $clog2(2 * DATA_W + 1);

  localparam logic [BCW-1:0] BAUD_BASE = BCW'(BAUD_DIV);
  localparam logic [SCW-1:0] SCLK_BASE = SCW'(SCLK_DIV);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_st_t;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_XFER, S_HOLD, S_GAP
  } sp_st_t;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_st_t;

  // ---------------- UART RX ----------------
  rx_st_t            rx_st;
  logic              rx_m, rx_s, rx_q;
  logic [BCW-1:0]    rx_per, rx_cnt;
  logic [BIW-1:0]    rx_bit;
  logic [DATA_W-1:0] rx_sh;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_m          <= 1'b1;
      rx_s          <= 1'b1;
      rx_q          <= 1'b1;
      rx_st         <= RX_IDLE;
      rx_per        <= '0;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_sh         <= '0;
      uart_rx_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      rx_m          <= bus.uart_rx_d_in;
      rx_s          <= rx_m;
      rx_q          <= rx_s;
      uart_rx_valid <= 1'b0;
      frame_err     <= 1'b0;
      rx_cnt        <= rx_cnt + BCW'(1);
      unique case (rx_st)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_q && !rx_s) begin
            rx_per <= BAUD_BASE << freq_control;
            rx_st  <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == (rx_per >> 1) - BCW'(1)) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= rx_s ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_cnt == rx_per - BCW'(1)) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s, rx_sh[DATA_W-1:1]};
            rx_bit <= rx_bit + BIW'(1);
            if (rx_bit == BIW'(DATA_W - 1))
              rx_st <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_cnt == rx_per - BCW'(1)) begin
            rx_cnt        <= '0;
            rx_st         <= RX_IDLE;
            uart_rx_valid <= rx_s;
            frame_err     <= !rx_s;
          end
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // ---------------- FIFO A (UART RX -> SPI) ----------------
  logic [DATA_W-1:0] a_mem [FIFO_DEPTH];
  logic [AW-1:0]     a_wp, a_rp;
  logic [CW-1:0]     a_cnt;
  logic              a_push, a_pop, a_full, a_wr;

  assign a_push = uart_rx_valid;
  assign a_full = (a_cnt == CW'(FIFO_DEPTH));
  assign a_wr   = a_push && (!a_full || a_pop);

  always_ff @(posedge clk) begin
    if (a_wr)
      a_mem[a_wp] <= rx_sh;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_wp  <= '0;
      a_rp  <= '0;
      a_cnt <= '0;
    end else begin
      if (a_wr)
        a_wp <= a_wp + AW'(1);
      if (a_pop)
        a_rp <= a_rp + AW'(1);
      a_cnt <= a_cnt + CW'(a_wr) - CW'(a_pop);
    end
  end

  // ---------------- SPI master ----------------
  sp_st_t            sp_st;
  logic [SCW-1:0]    sp_hp, sp_cnt;
  logic [EW-1:0]     sp_edges;
  logic              sp_cpha, sp_tick;
  logic [DATA_W-1:0] sp_tx, sp_rx;

  assign a_pop   = (sp_st == S_IDLE) && (a_cnt != '0) && spi_enable;
  assign sp_tick = (sp_cnt == sp_hp - SCW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_st        <= S_IDLE;
      bus.cs_bar   <= 1'b1;
      bus.sclk     <= 1'b0;
      bus.mosi     <= 1'b0;
      sp_hp        <= '0;
      sp_cnt       <= '0;
      sp_edges     <= '0;
      sp_cpha      <= 1'b0;
      sp_tx        <= '0;
      sp_rx        <= '0;
      spi_rx_valid <= 1'b0;
      spi_tx_done  <= 1'b0;
    end else begin
      spi_rx_valid <= 1'b0;
      spi_tx_done  <= 1'b0;
      sp_cnt       <= sp_cnt + SCW'(1);
      unique case (sp_st)
        S_IDLE: begin
          sp_cnt   <= '0;
          bus.sclk <= cpol;
          if (a_pop) begin
            sp_hp      <= SCLK_BASE << freq_control;
            sp_cpha    <= cpha;
            sp_tx      <= a_mem[a_rp];
            bus.mosi   <= a_mem[a_rp][DATA_W-1];
            bus.cs_bar <= 1'b0;
            sp_edges   <= '0;
            sp_st      <= S_SETUP;
          end
        end
        S_SETUP, S_XFER: begin
          if (sp_tick) begin
            sp_cnt <= '0;
            if (sp_edges == EW'(2 * DATA_W)) begin
              sp_st <= S_HOLD;
            end else begin
              sp_st    <= S_XFER;
              bus.sclk <= ~bus.sclk;
              sp_edges <= sp_edges + EW'(1);
              // even edge count = leading edge
              if (sp_edges[0] == sp_cpha) begin
                sp_rx <= {sp_rx[DATA_W-2:0], bus.miso};
              end else if (sp_cpha) begin
                bus.mosi <= sp_tx[DATA_W-1];
                sp_tx    <= sp_tx << 1;
              end else begin
                bus.mosi <= sp_tx[DATA_W-2];
                sp_tx    <= sp_tx << 1;
              end
            end
          end
        end
        S_HOLD: begin
          if (sp_tick) begin
            sp_cnt       <= '0;
            bus.cs_bar   <= 1'b1;
            spi_rx_valid <= 1'b1;
            spi_tx_done  <= 1'b1;
            sp_st        <= S_GAP;
          end
        end
        S_GAP: begin
          if (sp_tick) begin
            sp_cnt <= '0;
            sp_st  <= S_IDLE;
          end
        end
        default: sp_st <= S_IDLE;
      endcase
    end
  end

  // ---------------- FIFO B (SPI -> UART TX) ----------------
  logic [DATA_W-1:0] b_mem [FIFO_DEPTH];
  logic [AW-1:0]     b_wp, b_rp;
  logic [CW-1:0]     b_cnt;
  logic              b_push, b_pop, b_full, b_wr;

  assign b_push = spi_rx_valid;
  assign b_full = (b_cnt == CW'(FIFO_DEPTH));
  assign b_wr   = b_push && (!b_full || b_pop);

  always_ff @(posedge clk) begin
    if (b_wr)
      b_mem[b_wp] <= sp_rx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_wp  <= '0;
      b_rp  <= '0;
      b_cnt <= '0;
    end else begin
      if (b_wr)
        b_wp <= b_wp + AW'(1);
      if (b_pop)
        b_rp <= b_rp + AW'(1);
      b_cnt <= b_cnt + CW'(b_wr) - CW'(b_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      overflow <= 1'b0;
    else if ((a_push && a_full && !a_pop) ||
             (b_push && b_full && !b_pop))
      overflow <= 1'b1;
  end

  // ---------------- UART TX ----------------
  tx_st_t            tx_st;
  logic [BCW-1:0]    tx_per, tx_cnt;
  logic [BIW-1:0]    tx_bit;
  logic [DATA_W-1:0] tx_sh;
  logic              tx_tick;

  assign b_pop   = (tx_st == TX_IDLE) && (b_cnt != '0);
  assign tx_tick = (tx_cnt == tx_per - BCW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_st             <= TX_IDLE;
      bus.uart_tx_d_out <= 1'b1;
      uart_tx_ready     <= 1'b1;
      tx_per            <= '0;
      tx_cnt            <= '0;
      tx_bit            <= '0;
      tx_sh             <= '0;
    end else begin
      tx_cnt <= tx_cnt + BCW'(1);
      unique case (tx_st)
        TX_IDLE: begin
          tx_cnt <= '0;
          if (b_pop) begin
            tx_per            <= BAUD_BASE << freq_control;
            tx_sh             <= b_mem[b_rp];
            bus.uart_tx_d_out <= 1'b0;
            uart_tx_ready     <= 1'b0;
            tx_st             <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_cnt            <= '0;
            tx_bit            <= '0;
            bus.uart_tx_d_out <= tx_sh[0];
            tx_sh             <= tx_sh >> 1;
            tx_st             <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            tx_bit <= tx_bit + BIW'(1);
            if (tx_bit == BIW'(DATA_W - 1)) begin
              bus.uart_tx_d_out <= 1'b1;
              tx_st             <= TX_STOP;
            end else begin
              bus.uart_tx_d_out <= tx_sh[0];
              tx_sh             <= tx_sh >> 1;
            end
          end
        end
        TX_STOP: begin
          if (tx_tick) begin
            tx_cnt        <= '0;
            uart_tx_ready <= 1'b1;
            tx_st         <= TX_IDLE;
          end
        end
        default: tx_st <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_spi_bridge.sv
// Self-checking bench for uart_spi_bridge: UART peer, SPI slave
// model and queue-based reference of the end-to-end data path.
module tb_uart_spi_bridge;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int BAUD  = 16;
  localparam int SDIV  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] fc = 2'd0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       spi_enable = 1'b0;
  logic       uart_rx_valid, uart_tx_ready;
  logic       spi_rx_valid, spi_tx_done;
  logic       frame_err, overflow;

  uart_spi_bridge_if bus ();

  uart_spi_bridge #(
    .DATA_W(W), .FIFO_DEPTH(DEPTH),
    .BAUD_DIV(BAUD), .SCLK_DIV(SDIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .freq_control(fc),
    .cpol(cpol),
    .cpha(cpha),
    .spi_enable(spi_enable),
    .bus(bus),
    .uart_rx_valid(uart_rx_valid),
    .uart_tx_ready(uart_tx_ready),
    .spi_rx_valid(spi_rx_valid),
    .spi_tx_done(spi_tx_done),
    .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int n_rxv = 0, n_spiv = 0, n_done = 0, n_ferr = 0;
  int n_cslow = 0, n_rise = 0, n_frames = 0, n_txbad = 0;

  logic [W-1:0] resp_q[$];
  logic [W-1:0] mosi_q[$];
  logic [W-1:0] exp_tx_q[$];
  logic [W-1:0] uart_q[$];
  logic [W-1:0] exp_in[$];

  always @(negedge clk) begin
    if (uart_rx_valid) n_rxv++;
    if (spi_rx_valid)  n_spiv++;
    if (spi_tx_done)   n_done++;
    if (frame_err)     n_ferr++;
    if (!bus.cs_bar)   n_cslow++;
  end

  always @(posedge bus.sclk)
    if (!bus.cs_bar) n_rise++;

  // SPI slave: returns a response word, captures what MOSI carried
  logic [W-1:0] sl_tx, sl_rx, sl_resp;
  logic pcs = 1'b1;
  logic psclk = 1'b0;
  always @(bus.cs_bar or bus.sclk) begin
    if (pcs && !bus.cs_bar) begin
      sl_resp  = (resp_q.size() > 0) ? resp_q.pop_front() : W'($urandom);
      sl_tx    = sl_resp;
      sl_rx    = '0;
      bus.miso = sl_tx[W-1];
    end else if (!pcs && bus.cs_bar) begin
      if (reset) begin
        mosi_q.push_back(sl_rx);
        exp_tx_q.push_back(sl_resp);
        n_frames++;
      end
    end else if (!bus.cs_bar && bus.sclk !== psclk) begin
      if ((bus.sclk != cpol) != cpha) begin
        sl_rx = {sl_rx[W-2:0], bus.mosi};
      end else if (cpha) begin
        bus.miso = sl_tx[W-1];
        sl_tx    = sl_tx << 1;
      end else begin
        sl_tx    = sl_tx << 1;
        bus.miso = sl_tx[W-1];
      end
    end
    pcs   = bus.cs_bar;
    psclk = bus.sclk;
  end

  // UART peer receiver
  int           mon_p;
  logic [W-1:0] mon_d;
  always begin
    @(negedge bus.uart_tx_d_out);
    if (reset) begin
      mon_p = BAUD << fc;
      repeat (mon_p / 2) @(negedge clk);
      if (bus.uart_tx_d_out == 1'b0) begin
        for (int i = 0; i < W; i++) begin
          repeat (mon_p) @(negedge clk);
          mon_d[i] = bus.uart_tx_d_out;
        end
        repeat (mon_p) @(negedge clk);
        if (bus.uart_tx_d_out) uart_q.push_back(mon_d);
        else n_txbad++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic send_char(input logic [W-1:0] d, input logic stop);
    int p;
    p = BAUD << fc;
    bus.uart_rx_d_in = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < W; i++) begin
      bus.uart_rx_d_in = d[i];
      repeat (p) @(negedge clk);
    end
    bus.uart_rx_d_in = stop;
    repeat (p) @(negedge clk);
    bus.uart_rx_d_in = 1'b1;
  endtask

  task automatic wait_q(input int nm, input int nu, input int budget);
    int t;
    t = 0;
    while ((mosi_q.size() < nm || uart_q.size() < nu) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("wait_budget", 32'(t < budget), 32'd1);
    repeat (2 * (BAUD << fc)) @(negedge clk);
  endtask

  function automatic logic [31:0] qat(input logic [W-1:0] q[$], input int i);
    return (i < q.size()) ? 32'(q[i]) : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_q();
    resp_q.delete();
    mosi_q.delete();
    exp_tx_q.delete();
    uart_q.delete();
    exp_in.delete();
  endtask

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] resp;
    logic         cp;
    logic         ch;
    logic [1:0]   f;
    logic [W-1:0] exp_mosi;
    logic [W-1:0] exp_tx;
    int           exp_rise;
    int           exp_cslow;
  } vec_t;

  function automatic vec_t mk(input logic [W-1:0] din, input logic [W-1:0] resp,
                              input logic cp, input logic ch, input logic [1:0] f);
    vec_t v;
    v.din       = din;
    v.resp      = resp;
    v.cp        = cp;
    v.ch        = ch;
    v.f         = f;
    v.exp_mosi  = din;
    v.exp_tx    = resp;
    v.exp_rise  = W;
    v.exp_cslow = (2 * W + 2) * (SDIV << f);
    return v;
  endfunction

  vec_t vt[6];

  initial begin
    int s_rxv, s_spiv, s_done, s_ferr, s_cs, s_rise, s_fr, t;
    logic [W-1:0] d;

    vt[0] = mk(8'hA5, 8'h3C, 1'b0, 1'b0, 2'd0);
    vt[1] = mk(8'hA5, 8'h3C, 1'b1, 1'b1, 2'd0);
    vt[2] = mk(8'h5A, 8'hC3, 1'b0, 1'b1, 2'd1);
    vt[3] = mk(8'h00, 8'hFF, 1'b1, 1'b0, 2'd0);
    vt[4] = mk(8'hFF, 8'h00, 1'b0, 1'b0, 2'd2);
    vt[5] = mk(8'h81, 8'h7E, 1'b1, 1'b1, 2'd3);

    bus.uart_rx_d_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_bar", 32'(bus.cs_bar), 32'd1);
    check("rst_sclk", 32'(bus.sclk), 32'd0);
    check("rst_mosi", 32'(bus.mosi), 32'd0);
    check("rst_uart_tx", 32'(bus.uart_tx_d_out), 32'd1);
    check("rst_tx_ready", 32'(uart_tx_ready), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_pulses", 32'({uart_rx_valid, spi_rx_valid, spi_tx_done, frame_err}), 32'd0);

    reset = 1'b1;
    spi_enable = 1'b1;
    repeat (4) @(negedge clk);

    foreach (vt[k]) begin
      cpol = vt[k].cp;
      cpha = vt[k].ch;
      fc   = vt[k].f;
      repeat (4) @(negedge clk);
      check("idle_sclk_cpol", 32'(bus.sclk), 32'(vt[k].cp));
      clear_q();
      s_rxv = n_rxv; s_spiv = n_spiv; s_done = n_done;
      s_cs = n_cslow; s_rise = n_rise;
      resp_q.push_back(vt[k].resp);
      send_char(vt[k].din, 1'b1);
      wait_q(1, 1, 40 * (BAUD << fc));
      check("vec_frames", 32'(mosi_q.size()), 32'd1);
      check("vec_mosi", qat(mosi_q, 0), 32'(vt[k].exp_mosi));
      check("vec_uart_tx", qat(uart_q, 0), 32'(vt[k].exp_tx));
      check("vec_sclk_rise", 32'(n_rise - s_rise), 32'(vt[k].exp_rise));
      check("vec_cs_low", 32'(n_cslow - s_cs), 32'(vt[k].exp_cslow));
      check("vec_rx_valid", 32'(n_rxv - s_rxv), 32'd1);
      check("vec_spi_valid", 32'(n_spiv - s_spiv), 32'd1);
      check("vec_tx_done", 32'(n_done - s_done), 32'd1);
      check("vec_ready", 32'(uart_tx_ready), 32'd1);
    end

    // randomized back-to-back streams against queue reference
    for (int b = 0; b < 3; b++) begin
      cpol = 1'($urandom_range(0, 1));
      cpha = 1'($urandom_range(0, 1));
      fc   = 2'($urandom_range(0, 1));
      repeat (4) @(negedge clk);
      clear_q();
      for (int i = 0; i < 6; i++) begin
        d = W'($urandom);
        exp_in.push_back(d);
        send_char(d, 1'b1);
      end
      wait_q(6, 6, 20 * (BAUD << fc));
      check("rnd_nframes", 32'(mosi_q.size()), 32'd6);
      check("rnd_nuart", 32'(uart_q.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
        check("rnd_mosi", qat(mosi_q, i), qat(exp_in, i));
        check("rnd_uart", qat(uart_q, i), qat(exp_tx_q, i));
      end
    end
    check("rnd_no_overflow", 32'(overflow), 32'd0);

    cpol = 1'b0; cpha = 1'b0; fc = 2'd0;
    repeat (4) @(negedge clk);

    // framing error
    clear_q();
    s_rxv = n_rxv; s_ferr = n_ferr; s_fr = n_frames;
    send_char(8'h5A, 1'b0);
    repeat (4 * BAUD) @(negedge clk);
    check("ferr_pulse", 32'(n_ferr - s_ferr), 32'd1);
    check("ferr_no_valid", 32'(n_rxv - s_rxv), 32'd0);
    check("ferr_no_frame", 32'(n_frames - s_fr), 32'd0);
    check("ferr_cs_high", 32'(bus.cs_bar), 32'd1);

    // one-cycle glitch
    s_rxv = n_rxv; s_ferr = n_ferr; s_fr = n_frames;
    bus.uart_rx_d_in = 1'b0;
    @(negedge clk);
    bus.uart_rx_d_in = 1'b1;
    repeat (12 * BAUD) @(negedge clk);
    check("glitch_valid", 32'(n_rxv - s_rxv), 32'd0);
    check("glitch_ferr", 32'(n_ferr - s_ferr), 32'd0);
    check("glitch_frame", 32'(n_frames - s_fr), 32'd0);

    // FIFO A overflow with SPI gated off
    clear_q();
    spi_enable = 1'b0;
    s_fr = n_frames;
    for (int i = 1; i <= 5; i++) send_char(W'(i), 1'b1);
    repeat (4 * BAUD) @(negedge clk);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_gated", 32'(n_frames - s_fr), 32'd0);
    spi_enable = 1'b1;
    wait_q(DEPTH, DEPTH, 20 * DEPTH * BAUD);
    check("ovf_nframes", 32'(mosi_q.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      check("ovf_order", qat(mosi_q, i), 32'(i + 1));
      check("ovf_uart", qat(uart_q, i), qat(exp_tx_q, i));
    end
    check("ovf_sticky", 32'(overflow), 32'd1);

    // reset in the middle of a frame
    clear_q();
    s_fr = n_frames;
    send_char(8'hFF, 1'b1);
    t = 0;
    while (bus.cs_bar && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("xfer_started", 32'(t < 400), 32'd1);
    repeat (8) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_cs_bar", 32'(bus.cs_bar), 32'd1);
    check("arst_sclk", 32'(bus.sclk), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    check("arst_ready", 32'(uart_tx_ready), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("arst_no_frame", 32'(n_frames - s_fr), 32'd0);
    clear_q();
    send_char(8'h11, 1'b1);
    wait_q(1, 1, 40 * BAUD);
    repeat (4 * BAUD) @(negedge clk);
    check("post_rst_frames", 32'(mosi_q.size()), 32'd1);
    check("post_rst_mosi", qat(mosi_q, 0), 32'h11);
    check("post_rst_uart", qat(uart_q, 0), qat(exp_tx_q, 0));
    check("uart_stop_ok", 32'(n_txbad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_spi_bridge.md
Name: uart_spi_bridge

Overview:
Parametrised UART-to-SPI-master bridge; next generation of the UART/SPI loopback top.
Each word received on the UART is buffered, then shifted out as one SPI master frame. The word captured on MISO during that frame is buffered and retransmitted on the UART.
Adds configurable word width, FIFO depth, SPI mode (CPOL/CPHA), flow gating, overflow and framing-error reporting.

Parameters:
DATA_W, 8, bits per UART character and per SPI frame (4..16)
FIFO_DEPTH, 4, entries in each of the two FIFOs (power of 2, >=2)
BAUD_DIV, 16, clk cycles per UART bit at freq_control=0 (even, >=4)
SCLK_DIV, 2, clk cycles per SCLK half-period at freq_control=0 (>=1)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
freq_control  in  2  rate scaler: baud period = BAUD_DIV<<freq_control, half-period = SCLK_DIV<<freq_control
cpol  in  1  SPI clock idle level
cpha  in  1  SPI clock phase
spi_enable  in  1  1 = SPI FSM may start new frames
uart_rx_d_in  in  1  UART serial input, idle high
uart_tx_d_out  out  1  UART serial output, idle high
cs_bar  out  1  SPI chip select, active low
sclk  out  1  SPI clock
mosi  out  1  SPI data out, MSB first
miso  in  1  SPI data in
uart_rx_valid  out  1  1-cycle pulse: good character pushed to FIFO A
uart_tx_ready  out  1  UART TX FSM idle
spi_rx_valid  out  1  1-cycle pulse: MISO word pushed to FIFO B
spi_tx_done  out  1  1-cycle pulse: SPI frame completed
frame_err  out  1  1-cycle pulse: stop bit sampled 0
overflow  out  1  sticky: a push to a full FIFO occurred; cleared only by reset

Behaviour:
- Reset (reset=0, asynchronous): FIFOs empty, all FSMs idle; uart_tx_d_out=1, cs_bar=1, sclk=0, mosi=0, uart_tx_ready=1, all pulses=0, overflow=0. After release, sclk follows cpol within 1 cycle while idle. Reset mid-transfer aborts it: cs_bar rises asynchronously and no partial word is pushed.
- freq_control, cpol and cpha are latched at the start of each UART character and each SPI frame. Changes mid-character or mid-frame have no effect on that transfer.
- UART RX:
  - 2-flop synchroniser; falling edge starts the character.
  - Start bit re-checked at half-baud; if high, return to IDLE.
  - DATA_W bits sampled mid-bit, LSB first, then stop bit sampled mid-bit.
  - Stop=1: push to FIFO A and pulse uart_rx_valid. Stop=0: discard the character and pulse frame_err.
  - FSM states: IDLE, START, DATA, STOP.
- FIFO A/B:
  - Synchronous, FIFO_DEPTH entries, wrap-around pointers plus count.
  - Push while full: word dropped, overflow<=1.
  - Simultaneous push and pop while full: both succeed, no overflow.
  - Pop is never issued while empty.
- SPI master FSM (IDLE, SETUP, XFER, HOLD, GAP):
  - IDLE->SETUP when FIFO A non-empty and spi_enable=1. Pop the word, cs_bar<=0, sclk=cpol, mosi<=MSB. SETUP lasts one half-period.
  - XFER: 2*DATA_W sclk toggles, one per half-period.
    - cpha=0: sample miso on leading edges, shift mosi on trailing edges.
    - cpha=1: shift mosi on leading edges, sample miso on trailing edges.
  - HOLD: one half-period, then cs_bar<=1. Same cycle: push the captured word to FIFO B, pulse spi_rx_valid and spi_tx_done.
  - GAP: one half-period with cs_bar high, then IDLE.
  - spi_enable=0 mid-frame does not abort the frame.
  - Frame length with cs_bar low = (2*DATA_W+2) half-periods.
- UART TX:
  - IDLE->START when FIFO B non-empty: pop the word, uart_tx_ready<=0.
  - Sends start bit 0, DATA_W bits LSB first, stop bit 1, each lasting one baud period.
  - Returns to IDLE with uart_tx_ready=1.

Test Plan:
- DATA_W=8, BAUD_DIV=16, freq_control=0, mode 0; UART sends 0xA5, slave returns 0x3C -> mosi shows 10100101 MSB first; 8 rising sclk edges; cs_bar low 36 clk; uart_rx_valid, spi_rx_valid and spi_tx_done each pulse once; uart_tx_d_out carries 0x3C.
- Mode 3 (cpol=1, cpha=1), same data -> sclk idles high; miso sampled on rising edges; results identical to mode 0.
- spi_enable=0, send 0x01..0x05 -> 5th character dropped, overflow=1. Then spi_enable=1 -> exactly 4 frames 0x01..0x04 in order; overflow stays 1.
- UART character 0x5A with stop bit driven 0 -> frame_err pulses once; no uart_rx_valid; cs_bar stays high.
- 1-cycle glitch low on uart_rx_d_in -> no character accepted, no pulses.
- reset pulled low during XFER of 0xFF -> cs_bar=1 immediately, FIFOs empty. After release, sending 0x11 yields exactly one frame of 0x11.
